glyph_line_scheduler: RTL and testbench

Sequences a shared single-port glyph ROM for up to NUM_SLOTS on-screen glyph sprites, each drawn as an 8x8 glyph scaled 2x to 16x16 pixels.
- During horizontal blanking it scans the slot table and fetches one ROM row per slot that is vertically active on the next scanline, into shadow line buffers.
- At end of line it swaps the shadow buffers into the active buffers.
- During active video it emits a registered per-pixel hit flag and the winning slot index.
- Sits between hvsync_generator (hpos/vpos) and the colour-mux stage of VGA demos such as the gamepad viewer.

---
 rtl/glyph_sched_pkg.sv | 23 ++
 rtl/glyph_slot_pixel.sv | 22 ++
 rtl/glyph_line_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_glyph_line_scheduler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/glyph_sched_pkg.sv
// Shared timing constants, fetch FSM state type and ROM address packing
// for the glyph line scheduler.
package glyph_sched_pkg;

    localparam int H_ACTIVE    = 640;
    localparam int H_TOTAL     = 800;
    localparam int V_TOTAL     = 525;
    localparam int GLYPH_H     = 8;
    localparam int SCALE_SHIFT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_e;

    // Packs {glyph, row} into a wide word; callers keep the low GLYPH_IDX_W+3 bits.
    function automatic logic [15:0] rom_addr_pack(input logic [11:0] glyph,
                                                  input logic [2:0]  row);
        return {1'b0, glyph, row};
    endfunction

endpackage

// File: rtl/glyph_slot_pixel.sv
// Per-slot horizontal hit test: is hpos inside the 16-pixel-wide scaled glyph,
// and is the corresponding row bit lit.
module glyph_slot_pixel
    import glyph_sched_pkg::*;
(
    input  logic [9:0] hpos,
    input  logic [9:0] x,
    input  logic [7:0] row,
    output logic       hit
);

    logic [10:0] d;
    logic        in_range;
    logic [2:0]  col;

    // 11-bit difference: a borrow sets d[10], so hpos < x falls out of range.
    assign d        = {1'b0, hpos} - {1'b0, x};
    assign in_range = (d < 11'(GLYPH_H << SCALE_SHIFT));
    assign col      = 3'(GLYPH_H - 1) - 3'(d >> SCALE_SHIFT);
    assign hit      = in_range && row[col];

endmodule

// File: rtl/glyph_line_scheduler.sv
// Glyph sprite line scheduler: fetches one ROM row per slot during hblank into
// shadow buffers, swaps them in at end of line, and emits a registered hit/slot.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | waiting for hblank; rom_addr held at 0
//  ST_SCAN  | one slot per cycle: drive rom_addr, latch active flag and x
//  ST_DRAIN | capture ROM row for the last slot, then back to idle
module glyph_line_scheduler #(
    parameter  int NUM_SLOTS   = 12,
    parameter  int GLYPH_IDX_W = 4,
    parameter  int H_ACTIVE    = glyph_sched_pkg::H_ACTIVE,
    parameter  int H_TOTAL     = glyph_sched_pkg::H_TOTAL,
    parameter  int V_TOTAL     = glyph_sched_pkg::V_TOTAL,
    localparam int SW          = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int AW          = GLYPH_IDX_W + 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [9:0]             hpos,
    input  logic [9:0]             vpos,
    input  logic                   cfg_we,
    input  logic [SW-1:0]          cfg_slot,
    input  logic                   cfg_en,
    input  logic [9:0]             cfg_x,
    input  logic [9:0]             cfg_y,
    input  logic [GLYPH_IDX_W-1:0] cfg_glyph,
    output logic [AW-1:0]          rom_addr,
    input  logic [7:0]             rom_data,
    output logic                   pix_hit,
    output logic [SW-1:0]          pix_slot,
    output logic                   busy
);

    import glyph_sched_pkg::*;

    logic                   en_q    [NUM_SLOTS];
    logic                   en_d    [NUM_SLOTS];
    logic [9:0]             x_q     [NUM_SLOTS];
    logic [9:0]             x_d     [NUM_SLOTS];
    logic [9:0]             y_q     [NUM_SLOTS];
    logic [9:0]             y_d     [NUM_SLOTS];
    logic [GLYPH_IDX_W-1:0] glyph_q [NUM_SLOTS];
    logic [GLYPH_IDX_W-1:0] glyph_d [NUM_SLOTS];

    logic [7:0]             srow_q  [NUM_SLOTS];
    logic [7:0]             srow_d  [NUM_SLOTS];
    logic [9:0]             sx_q    [NUM_SLOTS];
    logic [9:0]             sx_d    [NUM_SLOTS];
    logic [7:0]             arow_q  [NUM_SLOTS];
    logic [7:0]             arow_d  [NUM_SLOTS];
    logic [9:0]             ax_q    [NUM_SLOTS];
    logic [9:0]             ax_d    [NUM_SLOTS];

    sched_state_e           state_q, state_d;
    logic [SW-1:0]          s_q, s_d;
    logic                   pipe_vld_q, pipe_vld_d;
    logic                   pipe_act_q, pipe_act_d;
    logic [9:0]             pipe_x_q, pipe_x_d;
    logic [SW-1:0]          pipe_s_q, pipe_s_d;
    logic                   pix_hit_q, pix_hit_d;
    logic [SW-1:0]          pix_slot_q, pix_slot_d;

    logic [9:0]             nl;
    logic [9:0]             ydiff;
    logic                   act_s;
    logic [2:0]             row_s;
    logic [15:0]            rom_addr_full;
    logic                   unused_rom_hi;
    logic [NUM_SLOTS-1:0]   slot_hit;

    assign nl    = (vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1;
    assign ydiff = nl - y_q[s_q];
    // 11-bit compare keeps y near the top of the 10-bit range from wrapping.
    assign act_s = en_q[s_q]
                && ({1'b0, nl} >= {1'b0, y_q[s_q]})
                && ({1'b0, nl} <  {1'b0, y_q[s_q]} + 11'(GLYPH_H << SCALE_SHIFT));
    assign row_s = 3'(ydiff >> SCALE_SHIFT);

    assign rom_addr_full = rom_addr_pack(12'(glyph_q[s_q]), row_s);
    assign unused_rom_hi = ^rom_addr_full[15:AW];

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            en_d[i]    = en_q[i];
            x_d[i]     = x_q[i];
            y_d[i]     = y_q[i];
            glyph_d[i] = glyph_q[i];
        end
        if (cfg_we && (32'(cfg_slot) < NUM_SLOTS)) begin
            en_d[cfg_slot]    = cfg_en;
            x_d[cfg_slot]     = cfg_x;
            y_d[cfg_slot]     = cfg_y;
            glyph_d[cfg_slot] = cfg_glyph;
        end
    end

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        pipe_vld_d = 1'b0;
        pipe_act_d = pipe_act_q;
        pipe_x_d   = pipe_x_q;
        pipe_s_d   = pipe_s_q;
        rom_addr   = '0;
        case (state_q)
            ST_IDLE: begin
                // Armed one pixel early so slot 0 is addressed at hpos == H_ACTIVE.
                if (hpos == 10'(H_ACTIVE - 1)) begin
                    state_d = ST_SCAN;
                    s_d     = '0;
                end
            end
            ST_SCAN: begin
                rom_addr   = rom_addr_full[AW-1:0];
                pipe_vld_d = 1'b1;
                pipe_act_d = act_s;
                pipe_x_d   = x_q[s_q];
                pipe_s_d   = s_q;
                if (32'(s_q) == NUM_SLOTS - 1) begin
                    state_d = ST_DRAIN;
                end else begin
                    s_d = s_q + 1'b1;
                end
            end
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            srow_d[i] = srow_q[i];
            sx_d[i]   = sx_q[i];
            arow_d[i] = arow_q[i];
            ax_d[i]   = ax_q[i];
        end
        if (pipe_vld_q) begin
            srow_d[pipe_s_q] = pipe_act_q ? rom_data : 8'h00;
            sx_d[pipe_s_q]   = pipe_x_q;
        end
        if (hpos == 10'(H_TOTAL - 1)) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                arow_d[i] = srow_q[i];
                ax_d[i]   = sx_q[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        glyph_slot_pixel u_pix (
            .hpos (hpos),
            .x    (ax_q[g]),
            .row  (arow_q[g]),
            .hit  (slot_hit[g])
        );
    end

    // Walk downwards so the lowest lit index is the last to assign.
    always_comb begin
        pix_hit_d  = 1'b0;
        pix_slot_d = '0;
        if (hpos < 10'(H_ACTIVE)) begin
            for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
                if (slot_hit[i]) begin
                    pix_hit_d  = 1'b1;
                    pix_slot_d = SW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                en_q[i]    <= 1'b0;
                x_q[i]     <= '0;
                y_q[i]     <= '0;
                glyph_q[i] <= '0;
                srow_q[i]  <= '0;
                sx_q[i]    <= '0;
                arow_q[i]  <= '0;
                ax_q[i]    <= '0;
            end
            state_q    <= ST_IDLE;
            s_q        <= '0;
            pipe_vld_q <= 1'b0;
            pipe_act_q <= 1'b0;
            pipe_x_q   <= '0;
            pipe_s_q   <= '0;
            pix_hit_q  <= 1'b0;
            pix_slot_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                en_q[i]    <= en_d[i];
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
                glyph_q[i] <= glyph_d[i];
                srow_q[i]  <= srow_d[i];
                sx_q[i]    <= sx_d[i];
                arow_q[i]  <= arow_d[i];
                ax_q[i]    <= ax_d[i];
            end
            state_q    <= state_d;
            s_q        <= s_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_act_q <= pipe_act_d;
            pipe_x_q   <= pipe_x_d;
            pipe_s_q   <= pipe_s_d;
            pix_hit_q  <= pix_hit_d;
            pix_slot_q <= pix_slot_d;
        end
    end

    assign pix_hit  = pix_hit_q;
    assign pix_slot = pix_slot_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_glyph_line_scheduler.sv
// Directed bench for glyph_line_scheduler: the bench plays sync generator and
// glyph ROM, runs whole scanlines and checks hand-computed hit/fetch results.
module tb_glyph_line_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] hpos, vpos;
    logic       cfg_we;
    logic [3:0] cfg_slot;
    logic       cfg_en;
    logic [9:0] cfg_x, cfg_y;
    logic [3:0] cfg_glyph;
    logic [6:0] rom_addr;
    logic [7:0] rom_data;
    logic       pix_hit;
    logic [3:0] pix_slot;
    logic       busy;

    logic [7:0] rom_mem [0:127];

    logic       hit_at  [0:799];
    logic [3:0] slot_at [0:799];
    int         hits, busy_cnt, busy_first;
    logic [6:0] addr640, addr_post;
    logic       busy_post;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    glyph_line_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hpos      (hpos),
        .vpos      (vpos),
        .cfg_we    (cfg_we),
        .cfg_slot  (cfg_slot),
        .cfg_en    (cfg_en),
        .cfg_x     (cfg_x),
        .cfg_y     (cfg_y),
        .cfg_glyph (cfg_glyph),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .pix_hit   (pix_hit),
        .pix_slot  (pix_slot),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
    task automatic step(input int h, input int v, input logic we, input logic rn);
        @(posedge clk);
        #1;
        hpos   = 10'(h);
        vpos   = 10'(v);
        cfg_we = we;
        rst_n  = rn;
        #1;
    endtask

    task automatic write_slot(input int s, input logic en, input int x, input int y, input int g);
        cfg_slot  = 4'(s);
        cfg_en    = en;
        cfg_x     = 10'(x);
        cfg_y     = 10'(y);
        cfg_glyph = 4'(g);
        step(700, 0, 1'b1, 1'b1);
        step(700, 0, 1'b0, 1'b1);
    endtask

    // Runs one full scanline; hit_at[p] holds the registered result for pixel p.
    task automatic run_line(input int v, input int cfg_h, input int rst_h);
        hits       = 0;
        busy_cnt   = 0;
        busy_first = -1;
        for (int h = 0; h < 800; h++) begin
            step(h, v, (h == cfg_h), (h != rst_h));
            if (h > 0) begin
                hit_at[h-1]  = pix_hit;
                slot_at[h-1] = pix_slot;
                if (pix_hit) hits++;
            end
            if (busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = h;
            end
            if (h == 640) addr640 = rom_addr;
            if (h == rst_h + 1) begin
                busy_post = busy;
                addr_post = rom_addr;
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        hpos      = 10'd700;
        vpos      = 10'd0;
        cfg_we    = 1'b0;
        cfg_slot  = '0;
        cfg_en    = 1'b0;
        cfg_x     = '0;
        cfg_y     = '0;
        cfg_glyph = '0;
        for (int i = 0; i < 128; i++) rom_mem[i] = 8'h00;
        for (int r = 0; r < 8; r++) rom_mem[3*8 + r] = 8'hFF;
        rom_mem[5*8 + 1] = 8'b1000_0001;

        step(700, 0, 1'b0, 1'b0);
        step(700, 0, 1'b0, 1'b0);
        step(700, 0, 1'b0, 1'b1);
        chk("rst_pix_hit", pix_hit, 0);
        chk("rst_pix_slot", pix_slot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rom_addr", rom_addr, 0);

        // Basic fetch and draw: slot 0, glyph 3 (all rows lit).
        write_slot(0, 1'b1, 100, 40, 3);
        run_line(39, -1, -1);
        chk("t1_rom_addr_640", addr640, 24);
        chk("t1_busy_cycles", busy_cnt, 13);
        chk("t1_busy_first", busy_first, 640);
        chk("t1_first_line_blank", hits, 0);
        run_line(40, -1, -1);
        chk("t1_hits", hits, 16);
        chk("t1_hit_99", hit_at[99], 0);
        chk("t1_hit_100", hit_at[100], 1);
        chk("t1_hit_115", hit_at[115], 1);
        chk("t1_hit_116", hit_at[116], 0);
        chk("t1_slot_100", slot_at[100], 0);

        // Row bit-select: glyph 5 row 1 = 1000_0001.
        write_slot(2, 1'b1, 300, 10, 5);
        run_line(11, -1, -1);
        run_line(12, -1, -1);
        chk("t2_hits", hits, 4);
        chk("t2_hit_300", hit_at[300], 1);
        chk("t2_hit_301", hit_at[301], 1);
        chk("t2_hit_302", hit_at[302], 0);
        chk("t2_hit_313", hit_at[313], 0);
        chk("t2_hit_314", hit_at[314], 1);
        chk("t2_hit_315", hit_at[315], 1);
        chk("t2_slot_300", slot_at[300], 2);

        // Overlap: slots 1 and 5 share a position; lowest index wins.
        write_slot(1, 1'b1, 200, 0, 3);
        write_slot(5, 1'b1, 200, 0, 3);
        run_line(0, -1, -1);
        run_line(1, -1, -1);
        chk("t3_hits", hits, 16);
        chk("t3_slot_200", slot_at[200], 1);
        chk("t3_slot_215", slot_at[215], 1);

        // Disabled slots, bottom-of-frame window, wrap to line 0.
        write_slot(1, 1'b0, 200, 0, 3);
        write_slot(5, 1'b0, 200, 0, 3);
        write_slot(6, 1'b1, 500, 0, 3);
        write_slot(7, 1'b1, 400, 520, 3);
        run_line(518, -1, -1);
        run_line(519, -1, -1);
        chk("t4_line519_hits", hits, 0);
        run_line(523, -1, -1);
        run_line(524, -1, -1);
        chk("t4_line524_hits", hits, 16);
        chk("t4_line524_slot_400", slot_at[400], 7);
        chk("t4_line524_hit_415", hit_at[415], 1);
        run_line(0, -1, -1);
        chk("t4_line0_hits", hits, 16);
        chk("t4_line0_hit_500", hit_at[500], 1);
        chk("t4_line0_slot_500", slot_at[500], 6);
        chk("t4_line0_slot7_off", hit_at[400], 0);
        chk("t4_line0_disabled", hit_at[200], 0);

        // Mid-scan rewrite of slot 11 (not yet scanned at hpos 643).
        write_slot(6, 1'b0, 500, 0, 3);
        write_slot(7, 1'b0, 400, 520, 3);
        write_slot(11, 1'b1, 100, 0, 3);
        cfg_slot  = 4'd11;
        cfg_en    = 1'b1;
        cfg_x     = 10'd600;
        cfg_y     = 10'd0;
        cfg_glyph = 4'd3;
        run_line(0, 643, -1);
        chk("t5_busy_cycles", busy_cnt, 13);
        chk("t5_busy_first", busy_first, 640);
        run_line(1, -1, -1);
        chk("t5_hits", hits, 16);
        chk("t5_old_x", hit_at[100], 0);
        chk("t5_new_x", hit_at[600], 1);
        chk("t5_slot_600", slot_at[600], 11);

        // Reset in the middle of a fetch.
        run_line(0, -1, 645);
        chk("t6_busy_cycles", busy_cnt, 6);
        chk("t6_busy_after", busy_post, 0);
        chk("t6_addr_after", addr_post, 0);
        run_line(1, -1, -1);
        chk("t6_no_hits", hits, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
